// File: rtl/transpose_pingpong.sv
// Double-buffered NxN block transposer: rows in, columns (or rows) out.
// Two banks ping-pong so one block fills while the other drains.
module transpose_pingpong #(
  parameter int DW = 12,
  parameter int N  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic            in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_data,
  output logic            out_last,
  output logic            blk_done
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [DW-1:0] mem_q [2][N][N];

  logic [1:0]    full_q, full_d;
  logic [1:0]    mode_q, mode_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_row_q, wr_row_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic          blk_done_q, blk_done_d;

  logic wr_acc, rd_acc, wr_end, rd_end;

  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_acc    = in_valid & in_ready;
  assign rd_acc    = out_valid & out_ready;
  assign wr_end    = wr_acc & (wr_row_q == LAST);
  assign rd_end    = rd_acc & (rd_idx_q == LAST);
  assign out_last  = out_valid & (rd_idx_q == LAST);
  assign blk_done  = blk_done_q;

  always_comb begin
    full_d     = full_q;
    mode_d     = mode_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_row_d   = wr_row_q;
    rd_idx_d   = rd_idx_q;
    blk_done_d = rd_end;
    if (wr_acc) begin
      wr_row_d = wr_end ? '0 : wr_row_q + AW'(1);
      if (wr_row_q == '0) mode_d[wr_bank_q] = in_mode;
      if (wr_end) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    // Set and clear never hit the same bank: writes only target non-full banks.
    if (rd_acc) begin
      rd_idx_d = rd_end ? '0 : rd_idx_q + AW'(1);
      if (rd_end) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      mode_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_row_q   <= '0;
      rd_idx_q   <= '0;
      blk_done_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      mode_q     <= mode_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_row_q   <= wr_row_d;
      rd_idx_q   <= rd_idx_d;
      blk_done_q <= blk_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int c = 0; c < N; c++) begin
        mem_q[wr_bank_q][wr_row_q][c] <= in_data[c*DW +: DW];
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int k = 0; k < N; k++) begin
        out_data[k*DW +: DW] = mode_q[rd_bank_q] ?
          mem_q[rd_bank_q][k][rd_idx_q] :
          mem_q[rd_bank_q][rd_idx_q][k];
      end
    end
  end

endmodule
